mem_port_scheduler: RTL

// - Shares the multi-read/single-write storage between two requesters: port 0 (instruction fetch, read-only) and port 1 (load/store, read or write).
// - Round-robin arbitration, one access in flight, fixed ACCESS_LAT-cycle occupancy, one-cycle response pulse.
// - Drives the storage read-enable/address/write bus; requesters never touch storage directly.

---
 rtl/mem_pkg.sv | 11 +
 rtl/mem_port_scheduler_rr_arbiter2.sv | 20 ++
 rtl/mem_port_scheduler.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the memory port scheduler.
package mem_pkg;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic PORT_FETCH = 1'b0;
  localparam logic PORT_LSU   = 1'b1;

  localparam int DEF_ADDR_SIZE = 28;
  localparam int DEF_ROW_WIDTH = 32;
  localparam int CNT_W         = 4;
endpackage

// File: rtl/mem_port_scheduler_rr_arbiter2.sv
// Two-requester round-robin arbiter; pointer names the favoured port on a tie.
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] gnt,
  output logic       gnt_port
);
  logic ptr;

  assign gnt_port = (req == 2'b11) ? ptr : req[1];
  assign gnt      = (req == 2'b00) ? 2'b00 : (gnt_port ? 2'b10 : 2'b01);

  // Loser of this grant is favoured next time.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)     ptr <= 1'b0;
    else if (upd) ptr <= ~gnt_port;
  end
endmodule

// File: rtl/mem_port_scheduler.sv
// Shares single-write/multi-read storage between fetch (port 0) and load/store (port 1).
module mem_port_scheduler
  import mem_pkg::*;
#(
  parameter int ADDR_SIZE  = DEF_ADDR_SIZE,
  parameter int ROW_WIDTH  = DEF_ROW_WIDTH,
  parameter int ACCESS_LAT = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req0_valid,
  input  logic [ADDR_SIZE-1:0]   req0_addr,
  output logic                   req0_ready,
  output logic                   resp0_valid,
  output logic [ROW_WIDTH-1:0]   resp0_data,
  input  logic                   req1_valid,
  input  logic                   req1_write,
  input  logic [ADDR_SIZE-1:0]   req1_addr,
  input  logic [ROW_WIDTH-1:0]   req1_wdata,
  output logic                   req1_ready,
  output logic                   resp1_valid,
  output logic [ROW_WIDTH-1:0]   resp1_data,
  output logic [2*ADDR_SIZE-1:0] st_readAddrs,
  output logic [1:0]             st_readEns,
  output logic [ADDR_SIZE-1:0]   st_writeAddr,
  output logic [ROW_WIDTH-1:0]   st_writeData,
  output logic                   st_writeEn,
  input  logic [ROW_WIDTH-1:0]   st_readData
);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(ACCESS_LAT - 1);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic                 port, wr;
  logic [ADDR_SIZE-1:0] addr;
  logic [ROW_WIDTH-1:0] wdata;
  logic [1:0]           gnt;
  logic                 gnt_port, any_req;

  assign any_req = req0_valid | req1_valid;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst      (rst),
    .req      ({req1_valid, req0_valid}),
    .upd      ((state == IDLE) & any_req),
    .gnt      (gnt),
    .gnt_port (gnt_port)
  );

  // Ready is masked by reset so every output reads 0 while reset is held.
  assign req0_ready  = rst & (state == IDLE) & gnt[0];
  assign req1_ready  = rst & (state == IDLE) & gnt[1];
  assign resp0_valid = (state == RESP) & (port == PORT_FETCH);
  assign resp1_valid = (state == RESP) & (port == PORT_LSU);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      port       <= PORT_FETCH;
      wr         <= 1'b0;
      addr       <= '0;
      wdata      <= '0;
      resp0_data <= '0;
      resp1_data <= '0;
    end else begin
      case (state)
        IDLE: if (any_req) begin
          port  <= gnt_port;
          wr    <= gnt_port & req1_write;
          addr  <= gnt_port ? req1_addr : req0_addr;
          wdata <= gnt_port ? req1_wdata : '0;
          cnt   <= '0;
          state <= ACCESS;
        end
        ACCESS: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST) begin
            if (wr)                    resp1_data <= '0;
            else if (port == PORT_LSU) resp1_data <= st_readData;
            else                       resp0_data <= st_readData;
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Storage bus is live only during ACCESS; the write strobe fires once on the last cycle.
  always_comb begin
    st_readAddrs = '0;
    st_readEns   = '0;
    st_writeAddr = '0;
    st_writeData = '0;
    st_writeEn   = 1'b0;
    if (state == ACCESS) begin
      if (wr) begin
        st_writeAddr = addr;
        st_writeData = wdata;
        st_writeEn   = (cnt == LAST);
      end else if (port == PORT_LSU) begin
        st_readAddrs[2*ADDR_SIZE-1:ADDR_SIZE] = addr;
        st_readEns[1] = 1'b1;
      end else begin
        st_readAddrs[ADDR_SIZE-1:0] = addr;
        st_readEns[0] = 1'b1;
      end
    end
  end
endmodule
